// File: rtl/fir3_datapath.sv
// fir3_datapath: 3-tap unsigned FIR datapath.
// Takes a packed coefficient word {c2, c1, c0} and a sample stream, keeps a
// 3-deep delay line and produces one filtered result per accepted sample
// once the line holds three samples.
// Pipeline: capture (delay line) -> multiply (p0..p2) -> sum (fir_out).
// Optional feature macro: FIR_SAT_EN clamps fir_out to 2^DATA_W-1 and raises
// sat_flag; without it fir_out is the full-precision sum and sat_flag is 0.
//
// Handshake: sample_valid is a one-sided valid with no ready. The block can
// always accept, so every edge that sees sample_valid=1 consumes sample_in.
// fir_valid is a one-cycle pulse; fir_out holds its value between pulses.
module fir3_datapath #(
  parameter int DATA_W  = 16,
  parameter int COEFF_W = 12,
  parameter int OUT_W   = DATA_W + COEFF_W + 2
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   clear,
  input  logic                   sample_valid,
  input  logic [DATA_W-1:0]      sample_in,
  input  logic [3*COEFF_W-1:0]   coeffs,
  output logic [OUT_W-1:0]       fir_out,
  output logic                   fir_valid,
  output logic                   sat_flag
);

  localparam int PROD_W = DATA_W + COEFF_W;

  // Delay line, fill counter and stage valids
  logic [DATA_W-1:0]  x0, x1, x2;
  logic [1:0]         fill;
  logic               v1, v2;

  // Product registers
  logic [PROD_W-1:0]  p0, p1, p2;

  // Coefficient slices and combinational products / sum
  logic [COEFF_W-1:0] c0, c1, c2;
  logic [PROD_W-1:0]  m0, m1, m2;
  logic [OUT_W-1:0]   sum;

  assign c0 = coeffs[COEFF_W-1:0];
  assign c1 = coeffs[2*COEFF_W-1:COEFF_W];
  assign c2 = coeffs[3*COEFF_W-1:2*COEFF_W];

  assign m0 = {{DATA_W{1'b0}}, c0} * {{COEFF_W{1'b0}}, x0};
  assign m1 = {{DATA_W{1'b0}}, c1} * {{COEFF_W{1'b0}}, x1};
  assign m2 = {{DATA_W{1'b0}}, c2} * {{COEFF_W{1'b0}}, x2};

  // Two guard bits above the product width make the 3-term sum exact
  assign sum = OUT_W'(p0) + OUT_W'(p1) + OUT_W'(p2);

  // Capture stage: shift in accepted samples, count fill, flag a full line
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      x0   <= '0;
      x1   <= '0;
      x2   <= '0;
      fill <= 2'd0;
      v1   <= 1'b0;
    end else if (clear) begin
      x0   <= '0;
      x1   <= '0;
      x2   <= '0;
      fill <= 2'd0;
      v1   <= 1'b0;
    end else if (sample_valid) begin
      x2   <= x1;
      x1   <= x0;
      x0   <= sample_in;
      fill <= (fill == 2'd3) ? 2'd3 : fill + 2'd1;
      // This sample completes the line when two were already held
      v1   <= (fill >= 2'd2);
    end else begin
      v1   <= 1'b0;
    end
  end

  // Multiply stage: products use the coefficients present at this edge
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      p0 <= '0;
      p1 <= '0;
      p2 <= '0;
      v2 <= 1'b0;
    end else if (clear) begin
      p0 <= '0;
      p1 <= '0;
      p2 <= '0;
      v2 <= 1'b0;
    end else begin
      p0 <= m0;
      p1 <= m1;
      p2 <= m2;
      v2 <= v1;
    end
  end

`ifdef FIR_SAT_EN
  localparam logic [OUT_W-1:0] SAT_MAX = {{(OUT_W-DATA_W){1'b0}}, {DATA_W{1'b1}}};

  // Sum stage with clamp: compare the full-width sum, update only on valid
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      fir_out   <= '0;
      fir_valid <= 1'b0;
      sat_flag  <= 1'b0;
    end else if (clear) begin
      fir_out   <= '0;
      fir_valid <= 1'b0;
      sat_flag  <= 1'b0;
    end else begin
      fir_valid <= v2;
      if (v2) begin
        if (sum > SAT_MAX) begin
          fir_out  <= SAT_MAX;
          sat_flag <= 1'b1;
        end else begin
          fir_out  <= sum;
          sat_flag <= 1'b0;
        end
      end
    end
  end
`else
  assign sat_flag = 1'b0;

  // Sum stage: full-precision result, held between valid pulses
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      fir_out   <= '0;
      fir_valid <= 1'b0;
    end else if (clear) begin
      fir_out   <= '0;
      fir_valid <= 1'b0;
    end else begin
      fir_valid <= v2;
      if (v2) begin
        fir_out <= sum;
      end
    end
  end
`endif

endmodule
